// File: rtl/ddr_a2m_pkg.sv
// ddr_a2m_pkg: shared encodings and the fixed-width part of the request
// record used by the DDR AXI->MBA request front end.
package ddr_a2m_pkg;

    // Direction of the presented request (AXDIR)
    localparam logic C_DIR_WR = 1'b0;
    localparam logic C_DIR_RD = 1'b1;

    // AXI burst type encodings
    typedef enum logic [1:0] {
        C_BURST_FIXED = 2'b00,
        C_BURST_INCR  = 2'b01,
        C_BURST_WRAP  = 2'b10
    } axburst_e;

    // Fixed-width tail of the request record {id, addr, len, size, burst, lock}.
    // The id/addr head depends on module parameters and is declared in the top.
    // Burst is kept as raw bits so the reserved code passes through untouched.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
    } req_ctl_t;

endpackage

// File: rtl/ddr_a2m_reqfifo.sv
// ddr_a2m_reqfifo: circular request queue of 2**P_FIFOD entries. Besides the
// head and occupancy it exposes a per-slot valid vector and all slots
// flattened, so a caller can compare against every queued entry.
module ddr_a2m_reqfifo #(
    parameter int P_FIFOD = 3,
    parameter int P_DW    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [P_DW-1:0]               din_i,
    input  logic                          pop_i,
    output logic [P_DW-1:0]               head_o,
    output logic [P_FIFOD:0]              cnt_o,
    output logic [2**P_FIFOD-1:0]         vld_o,
    output logic [(2**P_FIFOD)*P_DW-1:0]  ents_o
);
    localparam int C_DEPTH = 2 ** P_FIFOD;

    logic [P_DW-1:0]    mem_q [C_DEPTH];
    logic [P_FIFOD-1:0] wp_q, rp_q;
    logic [P_FIFOD:0]   cnt_q;

    // Pointers and occupancy; the caller never pushes when full or pops when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + P_FIFOD'(1);
            if (pop_i)  rp_q <= rp_q + P_FIFOD'(1);
            cnt_q <= cnt_q + (P_FIFOD+1)'(push_i) - (P_FIFOD+1)'(pop_i);
        end
    end

    // Entry storage (data only, not reset)
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end

    assign head_o = mem_q[rp_q];
    assign cnt_o  = cnt_q;

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        logic [P_FIFOD-1:0] off;
        vld_o = '0;
        off   = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            off      = P_FIFOD'(i) - rp_q;
            vld_o[i] = ({1'b0, off} < cnt_q);
        end
    end

    for (genvar g = 0; g < C_DEPTH; g++) begin : g_ents
        assign ents_o[g*P_DW +: P_DW] = mem_q[g];
    end

endmodule

// File: rtl/ddr_a2m_reqarb.sv
// ddr_a2m_reqarb: AW/AR request queues, read/write arbiter and a one-entry
// output register presented on the RE/EMPTY pop interface.
// Optional build macro: DDR_A2M_RAW_HAZARD_EN (read-after-write line hazard block).
module ddr_a2m_reqarb
    import ddr_a2m_pkg::*;
#(
    parameter int P_FIFOD  = 3,
    parameter int P_WIW    = 8,
    parameter int P_RIW    = 8,
    parameter int P_AW     = 40,
    parameter int P_RDPRI  = 1,
    parameter int P_STARVE = 8,
    parameter int P_LINE   = 6
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic [P_WIW-1:0]                            AWID,
    input  logic [P_AW-1:0]                             AWADDR,
    input  logic [7:0]                                  AWLEN,
    input  logic [2:0]                                  AWSIZE,
    input  logic [1:0]                                  AWBURST,
    input  logic                                        AWLOCK,
    input  logic                                        AWVALID,
    output logic                                        AWREADY,
    input  logic [P_RIW-1:0]                            ARID,
    input  logic [P_AW-1:0]                             ARADDR,
    input  logic [7:0]                                  ARLEN,
    input  logic [2:0]                                  ARSIZE,
    input  logic [1:0]                                  ARBURST,
    input  logic                                        ARLOCK,
    input  logic                                        ARVALID,
    output logic                                        ARREADY,
    input  logic                                        RE,
    output logic                                        EMPTY,
    output logic [((P_WIW > P_RIW) ? P_WIW : P_RIW)-1:0] AXID,
    output logic [P_AW-1:0]                             AXADDR,
    output logic [7:0]                                  AXLEN,
    output logic [2:0]                                  AXSIZE,
    output logic [1:0]                                  AXBURST,
    output logic                                        AXLOCK,
    output logic                                        AXDIR,
    output logic [P_FIFOD:0]                            WCNT,
    output logic [P_FIFOD:0]                            RCNT
);
    localparam int               P_IW     = (P_WIW > P_RIW) ? P_WIW : P_RIW;
    localparam int               C_DEPTH  = 2 ** P_FIFOD;
    localparam logic [P_FIFOD:0] C_FULL   = (P_FIFOD+1)'(C_DEPTH);
    localparam logic [7:0]       C_STARVE = 8'(P_STARVE);

    typedef struct packed {
        logic [P_IW-1:0] id;
        logic [P_AW-1:0] addr;
        req_ctl_t        ctl;
    } req_t;

    localparam int C_RW = $bits(req_t);

    req_t                    aw_req, ar_req, wr_head, rd_head, out_q, out_d;
    logic                    out_vld_q, out_vld_d, out_dir_q, out_dir_d, last_q, last_d;
    logic [7:0]              starve_q, starve_d;
    logic [P_FIFOD:0]        wcnt, rcnt;
    logic                    aw_push, ar_push, w_elig, r_elig, grant_rd, load, hz_match;
    logic [C_DEPTH-1:0]      wr_vld, unused_rd_vld;
    logic [C_DEPTH*C_RW-1:0] wr_ents, unused_rd_ents;

    // Ready depends only on the registered counts and reset, never on VALID
    assign AWREADY = ~RESET & (wcnt != C_FULL);
    assign ARREADY = ~RESET & (rcnt != C_FULL);
    assign aw_push = AWVALID & AWREADY;
    assign ar_push = ARVALID & ARREADY;

    // Pack incoming AW/AR beats into the common record, ids zero-extended
    always_comb begin
        aw_req     = '0;
        ar_req     = '0;
        aw_req.id  = P_IW'(AWID);
        aw_req.addr = AWADDR;
        aw_req.ctl = '{len: AWLEN, size: AWSIZE, burst: AWBURST, lock: AWLOCK};
        ar_req.id  = P_IW'(ARID);
        ar_req.addr = ARADDR;
        ar_req.ctl = '{len: ARLEN, size: ARSIZE, burst: ARBURST, lock: ARLOCK};
    end

    ddr_a2m_reqfifo #(.P_FIFOD(P_FIFOD), .P_DW(C_RW)) u_wq (
        .clk(CLK), .rst(RESET), .push_i(aw_push), .din_i(aw_req),
        .pop_i(load & ~grant_rd), .head_o(wr_head), .cnt_o(wcnt),
        .vld_o(wr_vld), .ents_o(wr_ents)
    );

    ddr_a2m_reqfifo #(.P_FIFOD(P_FIFOD), .P_DW(C_RW)) u_rq (
        .clk(CLK), .rst(RESET), .push_i(ar_push), .din_i(ar_req),
        .pop_i(load & grant_rd), .head_o(rd_head), .cnt_o(rcnt),
        .vld_o(unused_rd_vld), .ents_o(unused_rd_ents)
    );

`ifdef DDR_A2M_RAW_HAZARD_EN
    // Read head blocked while any queued or presented write hits its line
    always_comb begin
        req_t ent;
        hz_match = 1'b0;
        ent      = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            ent = req_t'(wr_ents[i*C_RW +: C_RW]);
            if (wr_vld[i] && (ent.addr[P_AW-1:P_LINE] == rd_head.addr[P_AW-1:P_LINE]))
                hz_match = 1'b1;
        end
        if (out_vld_q && (out_dir_q == C_DIR_WR) &&
            (out_q.addr[P_AW-1:P_LINE] == rd_head.addr[P_AW-1:P_LINE]))
            hz_match = 1'b1;
    end
`else
    logic unused_hz;
    assign unused_hz = ^{wr_vld, wr_ents};
    assign hz_match  = 1'b0;
`endif

    // Eligibility, winner selection and output-register load decision
    always_comb begin
        w_elig = (wcnt != '0);
        r_elig = (rcnt != '0) & ~hz_match;
        if (w_elig && r_elig) begin
            if (P_RDPRI != 0) grant_rd = (starve_q != C_STARVE);
            else              grant_rd = (last_q == C_DIR_WR);
        end else begin
            grant_rd = r_elig;
        end
        load = (~out_vld_q | RE) & (w_elig | r_elig);
    end

    // Next state of output register, starvation count and round-robin flag
    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        out_dir_d = out_dir_q;
        last_d    = last_q;
        starve_d  = starve_q;
        if (load) begin
            out_vld_d = 1'b1;
            out_dir_d = grant_rd ? C_DIR_RD : C_DIR_WR;
            out_d     = grant_rd ? rd_head : wr_head;
            last_d    = ~last_q;
        end else if (RE) begin
            out_vld_d = 1'b0;
        end
        if (wcnt == '0)             starve_d = '0;
        else if (load && !grant_rd) starve_d = '0;
        else if (load && grant_rd)  starve_d = starve_q + 8'd1;
    end

    // Arbiter state registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            out_dir_q <= C_DIR_WR;
            last_q    <= C_DIR_RD;
            starve_q  <= '0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            out_dir_q <= out_dir_d;
            last_q    <= last_d;
            starve_q  <= starve_d;
        end
    end

    assign EMPTY   = ~out_vld_q;
    assign AXID    = out_q.id;
    assign AXADDR  = out_q.addr;
    assign AXLEN   = out_q.ctl.len;
    assign AXSIZE  = out_q.ctl.size;
    assign AXBURST = out_q.ctl.burst;
    assign AXLOCK  = out_q.ctl.lock;
    assign AXDIR   = out_dir_q;
    assign WCNT    = wcnt;
    assign RCNT    = rcnt;

endmodule

// File: tb/tb_ddr_a2m_reqarb.sv
// tb_ddr_a2m_reqarb: drives one read-priority and one round-robin instance
// with shared stimulus and checks both against a queue-based model.
module tb_ddr_a2m_reqarb;
    import ddr_a2m_pkg::*;

    localparam int DEPTH  = 8;
    localparam int STARVE = 8;
    localparam int LINE   = 6;

    typedef struct packed {
        logic [7:0]  id;
        logic [39:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
    } req_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  AWID, ARID, AWLEN, ARLEN;
    logic [39:0] AWADDR, ARADDR;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWLOCK, ARLOCK, AWVALID, ARVALID, RE;

    logic        awrdy [2], ardy [2], emp [2], axlock [2], axdir [2];
    logic [7:0]  axid [2], axlen [2];
    logic [39:0] axaddr [2];
    logic [2:0]  axsize [2];
    logic [1:0]  axburst [2];
    logic [3:0]  wcnt [2], rcnt [2];

    always #5 CLK = ~CLK;

    ddr_a2m_reqarb #(.P_RDPRI(1), .P_STARVE(STARVE)) u_pri (
        .CLK(CLK), .RESET(RESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWVALID(AWVALID), .AWREADY(awrdy[0]),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARVALID(ARVALID), .ARREADY(ardy[0]),
        .RE(RE), .EMPTY(emp[0]), .AXID(axid[0]), .AXADDR(axaddr[0]), .AXLEN(axlen[0]),
        .AXSIZE(axsize[0]), .AXBURST(axburst[0]), .AXLOCK(axlock[0]), .AXDIR(axdir[0]),
        .WCNT(wcnt[0]), .RCNT(rcnt[0])
    );

    ddr_a2m_reqarb #(.P_RDPRI(0), .P_STARVE(STARVE)) u_rr (
        .CLK(CLK), .RESET(RESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWVALID(AWVALID), .AWREADY(awrdy[1]),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARVALID(ARVALID), .ARREADY(ardy[1]),
        .RE(RE), .EMPTY(emp[1]), .AXID(axid[1]), .AXADDR(axaddr[1]), .AXLEN(axlen[1]),
        .AXSIZE(axsize[1]), .AXBURST(axburst[1]), .AXLOCK(axlock[1]), .AXDIR(axdir[1]),
        .WCNT(wcnt[1]), .RCNT(rcnt[1])
    );

    // Reference model: two queues per instance, a presented slot, arbitration state
    req_t wq [2][$];
    req_t rq [2][$];
    req_t mout [2];
    logic mvld [2];
    logic mdir [2];
    logic mlast [2];
    int   mstarve [2];

    // Pop log taken from the DUT outputs
    logic        lg_dir [2][$];
    logic [39:0] lg_addr [2][$];
    int          lg_cyc [2][$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d actual=0x%0h expected=0x%0h cyc=%0d", nm, m, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int m);
        int   wn, rn;
        logic haz, wel, rel, grd, load, pop;
        req_t aw, ar;
        if (RESET) begin
            wq[m].delete();
            rq[m].delete();
            mvld[m]    = 1'b0;
            mout[m]    = '0;
            mdir[m]    = C_DIR_WR;
            mlast[m]   = C_DIR_RD;
            mstarve[m] = 0;
            return;
        end
        wn  = wq[m].size();
        rn  = rq[m].size();
        aw  = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK};
        ar  = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK};
        haz = 1'b0;
`ifdef DDR_A2M_RAW_HAZARD_EN
        if (rn > 0) begin
            for (int i = 0; i < wn; i++)
                if ((wq[m][i].addr >> LINE) == (rq[m][0].addr >> LINE)) haz = 1'b1;
            if (mvld[m] && mdir[m] == C_DIR_WR && ((mout[m].addr >> LINE) == (rq[m][0].addr >> LINE)))
                haz = 1'b1;
        end
`endif
        wel = (wn > 0);
        rel = (rn > 0) && !haz;
        if (wel && rel) grd = (m == 0) ? (mstarve[m] != STARVE) : (mlast[m] == C_DIR_WR);
        else            grd = rel;
        load = (!mvld[m] || RE) && (wel || rel);
        pop  = RE && mvld[m];
        if (wn == 0)             mstarve[m] = 0;
        else if (load && !grd)   mstarve[m] = 0;
        else if (load && grd)    mstarve[m] = mstarve[m] + 1;
        if (load) begin
            mlast[m] = !mlast[m];
            mvld[m]  = 1'b1;
            if (grd) begin mout[m] = rq[m].pop_front(); mdir[m] = C_DIR_RD; end
            else     begin mout[m] = wq[m].pop_front(); mdir[m] = C_DIR_WR; end
        end else if (pop) begin
            mvld[m] = 1'b0;
        end
        if (AWVALID && wn != DEPTH) wq[m].push_back(aw);
        if (ARVALID && rn != DEPTH) rq[m].push_back(ar);
    endtask

    always @(posedge CLK) begin
        cyc++;
        for (int m = 0; m < 2; m++) model_step(m);
    end

    // Per-cycle comparison against the model, plus DUT pop logging
    always @(negedge CLK) begin
        if (cyc > 0) begin
            for (int m = 0; m < 2; m++) begin
                chk("EMPTY", m, 64'(emp[m]), 64'(!mvld[m]));
                chk("WCNT", m, 64'(wcnt[m]), 64'(wq[m].size()));
                chk("RCNT", m, 64'(rcnt[m]), 64'(rq[m].size()));
                chk("AWREADY", m, 64'(awrdy[m]), 64'(!RESET && wq[m].size() != DEPTH));
                chk("ARREADY", m, 64'(ardy[m]), 64'(!RESET && rq[m].size() != DEPTH));
                if (mvld[m]) begin
                    chk("AXID", m, 64'(axid[m]), 64'(mout[m].id));
                    chk("AXADDR", m, 64'(axaddr[m]), 64'(mout[m].addr));
                    chk("AXLEN", m, 64'(axlen[m]), 64'(mout[m].len));
                    chk("AXSIZE", m, 64'(axsize[m]), 64'(mout[m].size));
                    chk("AXBURST", m, 64'(axburst[m]), 64'(mout[m].burst));
                    chk("AXLOCK", m, 64'(axlock[m]), 64'(mout[m].lock));
                    chk("AXDIR", m, 64'(axdir[m]), 64'(mdir[m]));
                end
                if (!RESET && RE && !emp[m]) begin
                    lg_dir[m].push_back(axdir[m]);
                    lg_addr[m].push_back(axaddr[m]);
                    lg_cyc[m].push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        RE      = 1'b0;
    endtask

    task automatic set_aw(input logic v, input logic [39:0] a);
        AWVALID = v;
        AWADDR  = a;
        AWID    = 8'($urandom);
        AWLEN   = 8'($urandom);
        AWSIZE  = 3'($urandom);
        AWBURST = 2'($urandom);
        AWLOCK  = 1'($urandom);
    endtask

    task automatic set_ar(input logic v, input logic [39:0] a);
        ARVALID = v;
        ARADDR  = a;
        ARID    = 8'($urandom);
        ARLEN   = 8'($urandom);
        ARSIZE  = 3'($urandom);
        ARBURST = 2'($urandom);
        ARLOCK  = 1'($urandom);
    endtask

    task automatic clear_logs();
        for (int m = 0; m < 2; m++) begin
            lg_dir[m].delete();
            lg_addr[m].delete();
            lg_cyc[m].delete();
        end
    endtask

    task automatic do_reset();
        idle();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        clear_logs();
    endtask

    logic [39:0] hz_exp [4];
    int          re_pct;

    initial begin
        RESET = 1'b1;
        idle();
        set_aw(1'b0, 40'h0);
        set_ar(1'b0, 40'h0);
        tick();
        tick();
        // Reset state
        for (int m = 0; m < 2; m++) begin
            chk("RST_EMPTY", m, 64'(emp[m]), 64'd1);
            chk("RST_WCNT", m, 64'(wcnt[m]), 64'd0);
            chk("RST_RCNT", m, 64'(rcnt[m]), 64'd0);
            chk("RST_AWREADY", m, 64'(awrdy[m]), 64'd0);
            chk("RST_ARREADY", m, 64'(ardy[m]), 64'd0);
            chk("RST_AXADDR", m, 64'(axaddr[m]), 64'd0);
            chk("RST_AXID", m, 64'(axid[m]), 64'd0);
            chk("RST_AXDIR", m, 64'(axdir[m]), 64'd0);
        end
        RESET = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) chk("REL_AWREADY", m, 64'(awrdy[m]), 64'd1);

        // Reset mid-burst with four writes queued behind the presented one
        for (int i = 0; i < 5; i++) begin
            set_aw(1'b1, 40'h100 + 40'(i * 64));
            tick();
        end
        AWVALID = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("MID_WCNT", m, 64'(wcnt[m]), 64'd4);
            chk("MID_EMPTY", m, 64'(emp[m]), 64'd0);
        end
        RESET = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("MIDRST_EMPTY", m, 64'(emp[m]), 64'd1);
            chk("MIDRST_WCNT", m, 64'(wcnt[m]), 64'd0);
            chk("MIDRST_AWREADY", m, 64'(awrdy[m]), 64'd0);
        end
        RESET = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) chk("MIDREL_AWREADY", m, 64'(awrdy[m]), 64'd1);

        // Fill: nine writes with no pops
        for (int i = 0; i < 9; i++) begin
            set_aw(1'b1, 40'h400 + 40'(i * 64));
            tick();
        end
        AWVALID = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("FILL_WCNT", m, 64'(wcnt[m]), 64'd8);
            chk("FILL_AWREADY", m, 64'(awrdy[m]), 64'd0);
            chk("FILL_EMPTY", m, 64'(emp[m]), 64'd0);
        end
        RE = 1'b1;
        tick();
        RE = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("FILL_POP_AWREADY", m, 64'(awrdy[m]), 64'd1);
            chk("FILL_POP_WCNT", m, 64'(wcnt[m]), 64'd7);
        end
        RE = 1'b1;
        repeat (12) tick();
        do_reset();

        // Read priority with starvation guard
        RE = 1'b1;
        set_aw(1'b1, 40'h8000);
        set_ar(1'b1, 40'h9000);
        tick();
        AWVALID = 1'b0;
        for (int i = 1; i < 20; i++) begin
            set_ar(1'b1, 40'h9000 + 40'(i * 64));
            tick();
        end
        ARVALID = 1'b0;
        repeat (12) tick();
        RE = 1'b0;
        chk("PRI_NPOP", 0, 64'(lg_dir[0].size()), 64'd21);
        for (int i = 0; i < 21; i++)
            if (i < lg_dir[0].size())
                chk("PRI_DIR", 0, 64'(lg_dir[0][i]), 64'((i == 8) ? C_DIR_WR : C_DIR_RD));
        do_reset();

        // Round robin: three writes and three reads queued, then drained
        for (int i = 0; i < 3; i++) begin
            set_aw(1'b1, 40'hA000 + 40'(i * 64));
            set_ar(1'b1, 40'hB000 + 40'(i * 64));
            tick();
        end
        idle();
        tick();
        tick();
        RE = 1'b1;
        repeat (8) tick();
        RE = 1'b0;
        chk("RR_NPOP", 1, 64'(lg_dir[1].size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < lg_dir[1].size()) begin
                chk("RR_DIR", 1, 64'(lg_dir[1][i]), 64'((i % 2 == 1) ? C_DIR_RD : C_DIR_WR));
                if (i > 0) chk("RR_GAP", 1, 64'(lg_cyc[1][i] - lg_cyc[1][i-1]), 64'd1);
            end
        end
        do_reset();

        // Line hazard: write 0x1000 queued behind 0x5000, then reads 0x1020 and 0x2000
`ifdef DDR_A2M_RAW_HAZARD_EN
        hz_exp = '{40'h5000, 40'h1000, 40'h1020, 40'h2000};
`else
        hz_exp = '{40'h5000, 40'h1020, 40'h2000, 40'h1000};
`endif
        set_aw(1'b1, 40'h5000);
        tick();
        set_aw(1'b1, 40'h1000);
        tick();
        AWVALID = 1'b0;
        set_ar(1'b1, 40'h1020);
        tick();
        set_ar(1'b1, 40'h2000);
        tick();
        idle();
        tick();
        tick();
        RE = 1'b1;
        repeat (8) tick();
        RE = 1'b0;
        chk("HZ_NPOP", 0, 64'(lg_addr[0].size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < lg_addr[0].size())
                chk("HZ_ORDER", 0, 64'(lg_addr[0][i]), 64'(hz_exp[i]));
        do_reset();

        // Randomized traffic with clustered addresses and occasional reset
        re_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) re_pct = (c / 250) % 3 == 0 ? 15 : ((c / 250) % 3 == 1 ? 50 : 90);
            RESET = ($urandom_range(0, 399) == 0);
            set_aw($urandom_range(0, 2) != 0, 40'h1000 + 40'($urandom_range(0, 7) * 32));
            set_ar($urandom_range(0, 2) != 0, 40'h1000 + 40'($urandom_range(0, 7) * 32));
            RE = ($urandom_range(0, 99) < re_pct);
            tick();
        end
        idle();
        RESET = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
